clk_div_prog: RTL and testbench

Programmable integer clock divider generalising the fixed divide-by-4 block to any ratio from 2 to 2^WIDTH-1. It produces a divided clock output, a one-cycle wrap tick, and a glitch-free runtime ratio change that takes effect only at a period boundary. It sits next to the fixed dividers in the clocking utilities and feeds slow enables and derived clocks to peripheral logic.

---
 rtl/clk_div_prog_if.sv | 27 ++
 rtl/clk_div_prog.sv | 105 ++++++++++
 tb/tb_clk_div_prog.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/clk_div_prog_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | clk_div_prog_if : control/status bundle of the programmable      |
// |                   clock divider. Revision 1.0                    |
// +------------------------------------------------------------------+
interface clk_div_prog_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] div_val;
  logic             out_clk;
  logic             tick;
  logic             upd_pend;
  logic [WIDTH-1:0] div_cur;

  modport master (
    output en, load, div_val,
    input  out_clk, tick, upd_pend, div_cur
  );

  modport slave (
    input  en, load, div_val,
    output out_clk, tick, upd_pend, div_cur
  );
endinterface
`default_nettype wire

// File: rtl/clk_div_prog.sv
`default_nettype none
// +------------------------------------------------------------------+
// | clk_div_prog : programmable integer clock divider (2..2^WIDTH-1) |
// |   with boundary-aligned ratio updates. CLKDIV_ODD_DUTY50_EN adds |
// |   a falling-edge flop for exact 50% duty on odd ratios. Rev 1.0  |
// +------------------------------------------------------------------+
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  wire logic      clk,
  input  wire logic      rst,
  clk_div_prog_if.slave  div_if
);

  localparam logic [WIDTH-1:0] c_def_div = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_two     = WIDTH'(2);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_cur_q, div_cur_d;
  logic [WIDTH-1:0] div_pend_q, div_pend_d;
  logic             upd_pend_q, upd_pend_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;

  logic [WIDTH-1:0] w_last;
  logic [WIDTH-1:0] w_half;
  logic             w_wrap;
  logic [WIDTH-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_div_clamped;

  assign w_last        = div_cur_q - c_one;
  assign w_half        = div_cur_q >> 1;
  assign w_wrap        = (cnt_q == w_last);
  assign w_cnt_next    = w_wrap ? '0 : (cnt_q + c_one);
  assign w_div_clamped = (div_if.div_val < c_two) ? c_two : div_if.div_val;

  always_comb begin
    cnt_d      = cnt_q;
    out_d      = out_q;
    tick_d     = 1'b0;
    div_cur_d  = div_cur_q;
    div_pend_d = div_pend_q;
    upd_pend_d = upd_pend_q;

    if (div_if.en) begin
      cnt_d  = w_cnt_next;
      out_d  = (w_cnt_next >= (div_cur_q - w_half));
      tick_d = (w_cnt_next == '0);
      // A load landing on the wrap edge replaces the pending ratio, so the
      // swap waits for the next wrap rather than using the stale value.
      if (w_wrap && upd_pend_q && !div_if.load) begin
        div_cur_d  = div_pend_q;
        upd_pend_d = 1'b0;
      end
    end

    if (div_if.load) begin
      div_pend_d = w_div_clamped;
      upd_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      div_cur_q  <= c_def_div;
      div_pend_q <= c_def_div;
      upd_pend_q <= 1'b0;
      out_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      div_pend_q <= div_pend_d;
      upd_pend_q <= upd_pend_d;
      out_q      <= out_d;
      tick_q     <= tick_d;
    end
  end

`ifdef CLKDIV_ODD_DUTY50_EN
  logic out_n_q;

  // Half-cycle delayed copy stretches the high phase by 0.5 cycle on odd ratios.
  always_ff @(negedge clk) begin
    if (rst) begin
      out_n_q <= 1'b0;
    end else begin
      out_n_q <= out_q;
    end
  end

  assign div_if.out_clk = div_cur_q[0] ? (out_q | out_n_q) : out_q;
`else
  assign div_if.out_clk = out_q;
`endif

  assign div_if.tick     = tick_q;
  assign div_if.upd_pend = upd_pend_q;
  assign div_if.div_cur  = div_cur_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_clk_div_prog : directed + randomized bench for clk_div_prog   |
// |   against a period-position reference model. Revision 1.0        |
// +------------------------------------------------------------------+
module tb_clk_div_prog;

  localparam int WIDTH = 8;
  localparam int DEF   = 4;

  logic clk = 1'b1;
  logic rst;

  always #5 clk = ~clk;

  clk_div_prog_if #(.WIDTH(WIDTH)) dif ();

  clk_div_prog #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position within the period, ratio in effect, pending ratio
  int m_pos   = 0;
  int m_n     = DEF;
  int m_pendn = DEF;
  bit m_pend  = 1'b0;
  bit m_out   = 1'b0;
  bit m_tick  = 1'b0;
  bit m_outn  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit l, input int dv);
    int nxt;
    bit wrap;
    bit exp_clk;
    rst          = r;
    dif.en       = e;
    dif.load     = l;
    dif.div_val  = dv[WIDTH-1:0];
    // falling edge happens between this drive and the next rising edge
    m_outn = r ? 1'b0 : m_out;
    @(posedge clk);
    if (r) begin
      m_pos = 0; m_n = DEF; m_pendn = DEF; m_pend = 1'b0;
      m_out = 1'b0; m_tick = 1'b0;
    end else begin
      nxt  = m_pos;
      wrap = e && (m_pos == m_n - 1);
      if (e) begin
        nxt    = (m_pos + 1) % m_n;
        m_tick = (nxt == 0);
        m_out  = (nxt >= (m_n + 1) / 2);
      end else begin
        m_tick = 1'b0;
      end
      if (wrap && m_pend && !l) begin
        m_n    = m_pendn;
        m_pend = 1'b0;
      end
      if (l) begin
        m_pendn = (dv < 2) ? 2 : dv;
        m_pend  = 1'b1;
      end
      m_pos = nxt;
    end
    #1;
    exp_clk = m_out;
`ifdef CLKDIV_ODD_DUTY50_EN
    if ((m_n % 2) == 1) exp_clk = m_out | m_outn;
`endif
    check("out_clk",  32'(dif.out_clk),  32'(exp_clk));
    check("tick",     32'(dif.tick),     32'(m_tick));
    check("upd_pend", 32'(dif.upd_pend), 32'(m_pend));
    check("div_cur",  32'(dif.div_cur),  32'(m_n));
  endtask

  task automatic run_to_last();
    int guard = 0;
    while ((m_pos != m_n - 1) && (guard < 600)) begin
      cyc(1'b0, 1'b1, 1'b0, 0);
      guard++;
    end
  endtask

  logic [3:0] pat4;
  logic [5:0] pat6;
  bit         held;

  initial begin
    dif.en      = 1'b0;
    dif.load    = 1'b0;
    dif.div_val = '0;
    rst         = 1'b1;
    pat4        = 4'b0110;
    pat6        = 6'b011100;

    repeat (3) cyc(1'b1, 1'b1, 1'b0, 0);
    check("rst_out",  32'(dif.out_clk),  32'(0));
    check("rst_tick", 32'(dif.tick),     32'(0));
    check("rst_div",  32'(dif.div_cur),  32'(DEF));

    for (int i = 1; i <= 12; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 0);
      check("div4_out",  32'(dif.out_clk), 32'(pat4[(i-1)%4]));
      check("div4_tick", 32'(dif.tick),    32'(i % 4 == 0));
    end

    // ratio 6 loaded mid-period
    cyc(1'b0, 1'b1, 1'b0, 0);
    cyc(1'b0, 1'b1, 1'b1, 6);
    check("ld6_pend", 32'(dif.upd_pend), 32'(1));
    check("ld6_old",  32'(dif.div_cur),  32'(4));
    cyc(1'b0, 1'b1, 1'b0, 0);
    check("ld6_still_old", 32'(dif.div_cur), 32'(4));
    cyc(1'b0, 1'b1, 1'b0, 0);
    check("ld6_new", 32'(dif.div_cur),  32'(6));
    check("ld6_clr", 32'(dif.upd_pend), 32'(0));
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 0);
      check("div6_out", 32'(dif.out_clk), 32'(pat6[i-1]));
    end

    // clamping of 0 and 1
    cyc(1'b0, 1'b1, 1'b1, 0);
    repeat (8) cyc(1'b0, 1'b1, 1'b0, 0);
    check("clamp0", 32'(dif.div_cur), 32'(2));
    cyc(1'b0, 1'b1, 1'b1, 1);
    repeat (4) cyc(1'b0, 1'b1, 1'b0, 0);
    check("clamp1",      32'(dif.div_cur),  32'(2));
    check("clamp1_pend", 32'(dif.upd_pend), 32'(0));
    repeat (6) cyc(1'b0, 1'b1, 1'b0, 0);

    // odd ratio
    cyc(1'b0, 1'b1, 1'b1, 5);
    repeat (4) cyc(1'b0, 1'b1, 1'b0, 0);
    check("div5", 32'(dif.div_cur), 32'(5));
    repeat (10) cyc(1'b0, 1'b1, 1'b0, 0);

    // load exactly on the wrap edge, then overwrite before the next wrap
    run_to_last();
    cyc(1'b0, 1'b1, 1'b1, 8);
    check("wrap_ld_hold", 32'(dif.div_cur),  32'(5));
    check("wrap_ld_pend", 32'(dif.upd_pend), 32'(1));
    cyc(1'b0, 1'b1, 1'b1, 10);
    repeat (6) cyc(1'b0, 1'b1, 1'b0, 0);
    check("second_ld", 32'(dif.div_cur), 32'(10));

    // enable low mid-period, then reset with a pending update
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 0);
    cyc(1'b0, 1'b1, 1'b1, 3);
    held = m_out;
    repeat (3) begin
      cyc(1'b0, 1'b0, 1'b0, 0);
      check("hold_out",  32'(dif.out_clk), 32'(held));
      check("hold_tick", 32'(dif.tick),    32'(0));
    end
    cyc(1'b1, 1'b1, 1'b0, 0);
    check("rst_mid_out",  32'(dif.out_clk),  32'(0));
    check("rst_mid_pend", 32'(dif.upd_pend), 32'(0));
    check("rst_mid_div",  32'(dif.div_cur),  32'(DEF));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, e, l;
      int dv;
      r  = ($urandom_range(0, 199) == 0);
      e  = ($urandom_range(0, 9) != 0);
      l  = ($urandom_range(0, 19) == 0);
      dv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                       : int'($urandom_range(0, 12));
      cyc(r, e, l, dv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
